rgb_mem_unit: RTL
=================

// Module: rgb_mem_unit
// PURPOSE
// - Memory stage downstream of the main decoder. Consumes MemWrite, ResultSrc (load) and RGB lane
//   select, and performs pixel-memory accesses: LDR/LDG/LDB/STR/STG/STB plus full-pixel LD/ST.
// - Channel stores need a read-modify-write on a sync-read single-port pixel RAM; this block sequences it.
// - The pipeline stalls on !req_ready.
// PARAMETERS
// - ADDR_W  16  pixel-address width (one word per pixel)
// - XLEN    32  register data width; rdata zero-extended to it
// - PIX_W   24  pixel word width; lanes R=[23:16] G=[15:8] B=[7:0]
// PORTS
// - clk        in   1       system clock, all state on rising edge
// - rst        in   1       synchronous reset, active-high
// - req_valid  in   1       memory op presented by execute stage
// - req_ready  out  1       op accepted this cycle when req_valid&&req_ready
// - mem_write  in   1       MemWrite from decoder (1=store)
// - mem_read   in   1       ResultSrc from decoder (1=load); mem_write&&mem_read is illegal and treated as store
// - rgb        in   2       00=full pixel, 01=R, 10=G, 11=B
// - addr       in   ADDR_W  pixel address (ALU result)
// - wdata      in   XLEN    store data; channel store uses wdata[7:0], full store uses wdata[23:0]
// - rdata      out  XLEN    load result, zero-extended
// - rdata_vld  out  1       one-cycle pulse when rdata is valid
// - ram_addr   out  ADDR_W  pixel RAM address
// - ram_we     out  1       pixel RAM write enable
// - ram_wdata  out  PIX_W   pixel RAM write data
// - ram_rdata  in   PIX_W   pixel RAM read data, valid one cycle after address presented with ram_we=0
// BEHAVIOUR
// - Reset values: state=IDLE, req_ready=1, rdata=0, rdata_vld=0, ram_we=0, ram_addr=0, ram_wdata=0.
// - FSM states are IDLE, LD_WAIT, LD_DONE, ST_RD, ST_WR.
// - req_ready=1 only in IDLE. An op with neither mem_write nor mem_read is accepted and ignored (no RAM activity).
// - IDLE: ram_addr driven combinationally from addr. Registers addr, rgb and wdata[23:0] on accept.
// - Full store (rgb=00): ram_we=1 and ram_wdata=wdata[23:0] in the accept cycle; stays IDLE; 0 stall cycles.
// - Load: accept -> LD_WAIT. ram_addr is held from the register in every non-IDLE state.
// - LD_WAIT -> LD_DONE: in LD_DONE, rdata <= extracted lane (or full 24b), zero-extended to XLEN.
//   rdata_vld pulses for 1 cycle, then IDLE. Latency accept->rdata_vld = 2 cycles; 2 stall cycles.
// - Channel store: accept (read issued) -> ST_RD (ram_rdata valid) -> ST_WR.
//   In ST_WR: ram_we=1, ram_wdata = ram_rdata captured in ST_RD with the selected lane replaced by wdata[7:0].
//   Then IDLE. Exactly one write pulse; 2 stall cycles.
// - rdata holds its last value between loads; rdata_vld is 0 except in the LD_DONE cycle.
// - ram_we=0 in every state except the full-store accept cycle and ST_WR.
// - Back-to-back ops: the next op may be accepted in the cycle after LD_DONE/ST_WR. A load right after a
//   channel store to the same address returns the merged pixel; RAM is read-after-write coherent.
// - Address wrap: addr is used as-is, ADDR_W bits, no bounds check.
// - rst mid-operation: next state IDLE; an in-flight ST_WR write is suppressed if rst is high in that cycle.
//   No rdata_vld follows.
// - Inputs are ignored while req_ready=0. Upstream holds them stable until accepted.
// STRUCTURE
// - rgb_pkg: rgb_sel_e {RGB_FULL=2'b00, RGB_R, RGB_G, RGB_B}; lane LSB constants R_LSB=16, G_LSB=8, B_LSB=0;
//   mem_state_e.
// - Sub-module rgb_lane_merge (combinational): extract(pixel,sel)->8/24b and merge(pixel,byte,sel)->24b.
//   Shared with the testbench model.
// - The top holds the FSM and request registers only.
// TESTING
// - Reset then idle: rst=1 for 2 cycles -> req_ready=1, ram_we=0, rdata_vld=0, rdata=0.
// - Full store then full load: ST addr=0x0010, wdata=0x00A1B2C3.
//   -> ram_we=1 in the accept cycle with ram_wdata=0xA1B2C3, req_ready stays 1.
//   LD rgb=00 addr=0x0010 -> rdata_vld 2 cycles later, rdata=0x00A1B2C3.
// - Channel loads on pixel 0xA1B2C3: LDR -> 0x000000A1, LDG -> 0x000000B2, LDB -> 0x000000C3.
//   Each gives exactly one rdata_vld pulse and req_ready=0 for 2 cycles.
// - Channel store RMW: pixel 0xA1B2C3, STG wdata=0xFFFFFF5E -> single ram_we pulse in ST_WR with
//   ram_wdata=0xA15EC3. Following LD rgb=00 returns 0x00A15EC3.
// - Back-to-back STR 0x11 then LDR at the same address, req_valid held high -> second op accepted in the cycle
//   after ST_WR; rdata=0x00000011.
// - Reset mid-RMW: assert rst in the ST_WR cycle of an STB -> no ram_we, RAM pixel unchanged,
//   state IDLE, req_ready=1 next cycle.

Source files
------------

// File: rtl/rgb_pkg.sv
// Shared types and lane geometry for the RGB pixel-memory stage.
package rgb_pkg;

    // Lane select as decoded from the instruction's rgb field.
    typedef enum logic [1:0] {
        RGB_FULL = 2'b00,
        RGB_R    = 2'b01,
        RGB_G    = 2'b10,
        RGB_B    = 2'b11
    } rgb_sel_e;

    // Memory-stage sequencer states.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LD_WAIT = 3'd1,
        LD_DONE = 3'd2,
        ST_RD   = 3'd3,
        ST_WR   = 3'd4
    } mem_state_e;

    localparam int unsigned PIXEL_W = 24;
    localparam int unsigned LANE_W  = 8;
    localparam int unsigned R_LSB   = 16;
    localparam int unsigned G_LSB   = 8;
    localparam int unsigned B_LSB   = 0;

endpackage

// File: rtl/rgb_lane_merge.sv
// Combinational lane helper: extracts one colour lane (or the whole pixel)
// and builds a pixel with one lane replaced by a new byte.
module rgb_lane_merge
    import rgb_pkg::*;
(
    input  logic [PIXEL_W-1:0] pixel,
    input  logic [1:0]         sel,
    input  logic [LANE_W-1:0]  lane_byte,
    output logic [PIXEL_W-1:0] lane_out,
    output logic [PIXEL_W-1:0] merged
);

    // Select the addressed lane for reads and splice the new byte for writes.
    always_comb begin
        lane_out = pixel;
        merged   = pixel;
        case (rgb_sel_e'(sel))
            RGB_R: begin
                lane_out                 = '0;
                lane_out[LANE_W-1:0]     = pixel[R_LSB +: LANE_W];
                merged[R_LSB +: LANE_W]  = lane_byte;
            end
            RGB_G: begin
                lane_out                 = '0;
                lane_out[LANE_W-1:0]     = pixel[G_LSB +: LANE_W];
                merged[G_LSB +: LANE_W]  = lane_byte;
            end
            RGB_B: begin
                lane_out                 = '0;
                lane_out[LANE_W-1:0]     = pixel[B_LSB +: LANE_W];
                merged[B_LSB +: LANE_W]  = lane_byte;
            end
            default: begin
                lane_out = pixel;
                merged   = pixel;
            end
        endcase
    end

endmodule

// File: rtl/rgb_mem_unit.sv
// Pixel-memory stage: full-pixel and per-channel loads/stores against a
// sync-read single-port pixel RAM, with read-modify-write for channel stores.
module rgb_mem_unit #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned XLEN   = 32,
    parameter int unsigned PIX_W  = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              mem_write,
    input  logic              mem_read,
    input  logic [1:0]        rgb,
    input  logic [ADDR_W-1:0] addr,
    input  logic [XLEN-1:0]   wdata,
    output logic [XLEN-1:0]   rdata,
    output logic              rdata_vld,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [PIX_W-1:0]  ram_wdata,
    input  logic [PIX_W-1:0]  ram_rdata
);
    import rgb_pkg::*;

    mem_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    rgb_sel_e          rgb_q, rgb_d;
    logic [PIX_W-1:0]  wdata_q, wdata_d;
    logic [PIX_W-1:0]  pix_q, pix_d;
    logic [PIX_W-1:0]  rdata_q, rdata_d;

    logic [PIX_W-1:0]  lane_out;
    logic [PIX_W-1:0]  merged;
    logic              unused_bits;

    // Lane logic always works on the live RAM read data: it feeds the load
    // result in LD_WAIT and the merged pixel in ST_RD.
    rgb_lane_merge u_lane (
        .pixel     (ram_rdata),
        .sel       (rgb_q),
        .lane_byte (wdata_q[LANE_W-1:0]),
        .lane_out  (lane_out),
        .merged    (merged)
    );

    assign req_ready   = (state_q == IDLE);
    assign rdata       = XLEN'(rdata_q);
    assign unused_bits = ^{wdata[XLEN-1:PIX_W], wdata_q[PIX_W-1:LANE_W]};

    // Next-state, request capture and RAM port drive.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rgb_d     = rgb_q;
        wdata_d   = wdata_q;
        pix_d     = pix_q;
        rdata_d   = rdata_q;
        ram_addr  = addr_q;
        ram_we    = 1'b0;
        ram_wdata = '0;
        rdata_vld = 1'b0;

        case (state_q)
            IDLE: begin
                ram_addr = addr;
                if (req_valid) begin
                    addr_d  = addr;
                    rgb_d   = rgb_sel_e'(rgb);
                    wdata_d = wdata[PIX_W-1:0];
                    if (mem_write) begin
                        if (rgb_sel_e'(rgb) == RGB_FULL) begin
                            ram_we    = 1'b1;
                            ram_wdata = wdata[PIX_W-1:0];
                        end else begin
                            state_d = ST_RD;
                        end
                    end else if (mem_read) begin
                        state_d = LD_WAIT;
                    end
                end
            end
            LD_WAIT: begin
                rdata_d = lane_out;
                state_d = LD_DONE;
            end
            LD_DONE: begin
                rdata_vld = 1'b1;
                state_d   = IDLE;
            end
            ST_RD: begin
                // The merge is done while capturing, so ST_WR just replays pix_q.
                pix_d   = merged;
                state_d = ST_WR;
            end
            ST_WR: begin
                ram_we    = 1'b1;
                ram_wdata = pix_q;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (rst) begin
            ram_addr  = '0;
            ram_we    = 1'b0;
            ram_wdata = '0;
            rdata_vld = 1'b0;
        end
    end

    // State and request registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rgb_q   <= RGB_FULL;
            wdata_q <= '0;
            pix_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rgb_q   <= rgb_d;
            wdata_q <= wdata_d;
            pix_q   <= pix_d;
            rdata_q <= rdata_d;
        end
    end

endmodule
